// File: rtl/spi_apb_arbiter.sv
// Two-port round-robin APB arbiter in front of the SPI bridge slave port.
// Define SPI_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins every tie).
`timescale 1ns/1ps

`ifndef P_ADDR_W
`define P_ADDR_W 32
`endif
`ifndef P_DATA_W
`define P_DATA_W 32
`endif
`ifndef P_STRB_W
`define P_STRB_W 4
`endif

module spi_apb_arbiter #(
    parameter int ADDR_W = `P_ADDR_W,
    parameter int DATA_W = `P_DATA_W,
    parameter int STRB_W = `P_STRB_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [ADDR_W-1:0] s0_paddr,
    input  logic              s0_psel,
    input  logic              s0_penable,
    input  logic [2:0]        s0_pprot,
    input  logic              s0_pwrite,
    input  logic [DATA_W-1:0] s0_pwdata,
    input  logic [STRB_W-1:0] s0_pstrb,
    output logic              s0_pready,
    output logic [DATA_W-1:0] s0_prdata,
    output logic              s0_pslverr,
    input  logic [ADDR_W-1:0] s1_paddr,
    input  logic              s1_psel,
    input  logic              s1_penable,
    input  logic [2:0]        s1_pprot,
    input  logic              s1_pwrite,
    input  logic [DATA_W-1:0] s1_pwdata,
    input  logic [STRB_W-1:0] s1_pstrb,
    output logic              s1_pready,
    output logic [DATA_W-1:0] s1_prdata,
    output logic              s1_pslverr,
    output logic [ADDR_W-1:0] m_paddr,
    output logic [2:0]        m_pprot,
    output logic              m_pwrite,
    output logic [DATA_W-1:0] m_pwdata,
    output logic [STRB_W-1:0] m_pstrb,
    output logic              m_psel,
    output logic              m_penable,
    input  logic              m_pready,
    input  logic [DATA_W-1:0] m_prdata,
    input  logic              m_pslverr
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    logic [1:0]        r_state;
    logic              r_gnt;
    logic [ADDR_W-1:0] r_paddr;
    logic [2:0]        r_pprot;
    logic              r_pwrite;
    logic [DATA_W-1:0] r_pwdata;
    logic [STRB_W-1:0] r_pstrb;

    logic w_any_req;
    logic w_gnt_nxt;
    logic w_access;
    logic w_sel0;
    logic w_sel1;

    assign w_any_req = s0_psel | s1_psel;

`ifdef SPI_ARB_FIXED_PRIO_EN
    assign w_gnt_nxt = ~s0_psel;
`else
    logic r_last;

    // The port not served last wins a tie; r_last=1 lets port 0 take the first one.
    assign w_gnt_nxt = (s0_psel & s1_psel) ? ~r_last : ~s0_psel;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_last <= 1'b1;
        end else if (r_state == ST_IDLE && w_any_req) begin
            r_last <= w_gnt_nxt;
        end
    end
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= ST_IDLE;
            r_gnt    <= 1'b0;
            r_paddr  <= '0;
            r_pprot  <= '0;
            r_pwrite <= 1'b0;
            r_pwdata <= '0;
            r_pstrb  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_state  <= ST_SETUP;
                        r_gnt    <= w_gnt_nxt;
                        r_paddr  <= w_gnt_nxt ? s1_paddr  : s0_paddr;
                        r_pprot  <= w_gnt_nxt ? s1_pprot  : s0_pprot;
                        r_pwrite <= w_gnt_nxt ? s1_pwrite : s0_pwrite;
                        r_pwdata <= w_gnt_nxt ? s1_pwdata : s0_pwdata;
                        r_pstrb  <= w_gnt_nxt ? s1_pstrb  : s0_pstrb;
                    end
                end
                ST_SETUP:  r_state <= ST_ACCESS;
                ST_ACCESS: if (m_pready) r_state <= ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_access = (r_state == ST_ACCESS);
    assign w_sel0   = w_access & ~r_gnt;
    assign w_sel1   = w_access &  r_gnt;

    assign m_psel    = (r_state != ST_IDLE);
    assign m_penable = w_access;
    assign m_paddr   = r_paddr;
    assign m_pprot   = r_pprot;
    assign m_pwrite  = r_pwrite;
    assign m_pwdata  = r_pwdata;
    assign m_pstrb   = r_pstrb;

    // A requester that has dropped psel gets no pready; its response is discarded.
    assign s0_pready  = w_sel0 & m_pready & s0_psel & s0_penable;
    assign s1_pready  = w_sel1 & m_pready & s1_psel & s1_penable;
    assign s0_prdata  = w_sel0 ? m_prdata : '0;
    assign s1_prdata  = w_sel1 ? m_prdata : '0;
    assign s0_pslverr = w_sel0 & m_pslverr;
    assign s1_pslverr = w_sel1 & m_pslverr;

endmodule

// File: tb/tb_spi_apb_arbiter.sv
// Scoreboard bench for spi_apb_arbiter: requester tasks plus a downstream bridge model.
`timescale 1ns/1ps

module tb_spi_apb_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] s0_paddr, s1_paddr, s0_pwdata, s1_pwdata, s0_prdata, s1_prdata;
    logic        s0_psel, s1_psel, s0_penable, s1_penable, s0_pwrite, s1_pwrite;
    logic [2:0]  s0_pprot, s1_pprot, m_pprot;
    logic [3:0]  s0_pstrb, s1_pstrb, m_pstrb;
    logic        s0_pready, s1_pready, s0_pslverr, s1_pslverr;
    logic [31:0] m_paddr, m_pwdata, m_prdata;
    logic        m_pwrite, m_psel, m_penable, m_pready, m_pslverr;

    always #5 clk = ~clk;

    spi_apb_arbiter #(.ADDR_W(32), .DATA_W(32), .STRB_W(4)) dut (
        .clk(clk), .resetn(resetn),
        .s0_paddr(s0_paddr), .s0_psel(s0_psel), .s0_penable(s0_penable), .s0_pprot(s0_pprot),
        .s0_pwrite(s0_pwrite), .s0_pwdata(s0_pwdata), .s0_pstrb(s0_pstrb),
        .s0_pready(s0_pready), .s0_prdata(s0_prdata), .s0_pslverr(s0_pslverr),
        .s1_paddr(s1_paddr), .s1_psel(s1_psel), .s1_penable(s1_penable), .s1_pprot(s1_pprot),
        .s1_pwrite(s1_pwrite), .s1_pwdata(s1_pwdata), .s1_pstrb(s1_pstrb),
        .s1_pready(s1_pready), .s1_prdata(s1_prdata), .s1_pslverr(s1_pslverr),
        .m_paddr(m_paddr), .m_pprot(m_pprot), .m_pwrite(m_pwrite), .m_pwdata(m_pwdata),
        .m_pstrb(m_pstrb), .m_psel(m_psel), .m_penable(m_penable),
        .m_pready(m_pready), .m_prdata(m_prdata), .m_pslverr(m_pslverr)
    );

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
    } dn_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    dn_t  dn_q[$];
    rsp_t rsp_q0[$];
    rsp_t rsp_q1[$];

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] br_base = 32'h0;
    int          br_wait = 0;
    logic        br_err  = 1'b0;
    logic        tb_last = 1'b1;

    // Bridge model: checks forwarded fields against the expected grant order.
    initial begin : bridge
        int          cnt;
        logic [31:0] held;
        dn_t         e;
        cnt = 0;
        held = '0;
        m_pready = 1'b0; m_prdata = '0; m_pslverr = 1'b0;
        forever begin
            @(negedge clk);
            if (resetn && m_psel && m_penable) begin
                if (cnt == 0) begin
                    n_cmp++;
                    if (dn_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL dn_unexpected: got addr %h, required no transfer", m_paddr);
                    end else begin
                        e = dn_q.pop_front();
                        if ({m_paddr, m_pwrite, m_pwdata, m_pstrb, m_pprot} !==
                            {e.addr, e.wr, e.wdata, e.strb, e.prot}) begin
                            n_bad++;
                            $display("FAIL dn_fields: got a=%h w=%b d=%h s=%h p=%h, required a=%h w=%b d=%h s=%h p=%h",
                                     m_paddr, m_pwrite, m_pwdata, m_pstrb, m_pprot,
                                     e.addr, e.wr, e.wdata, e.strb, e.prot);
                        end
                    end
                    held = m_paddr;
                end else begin
                    n_cmp++;
                    if (m_paddr !== held) begin
                        n_bad++;
                        $display("FAIL dn_addr_stable: got %h, required %h", m_paddr, held);
                    end
                end
                if (cnt >= br_wait) begin
                    m_pready = 1'b1; m_prdata = br_base ^ m_paddr; m_pslverr = br_err;
                end else begin
                    m_pready = 1'b0; m_prdata = $urandom; m_pslverr = 1'b0;
                end
                cnt++;
            end else begin
                m_pready = 1'b0; m_prdata = '0; m_pslverr = 1'b0;
                cnt = 0;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic expect_dn(input logic [31:0] a, input logic w, input logic [31:0] d,
                             input logic [3:0] s, input logic [2:0] p);
        dn_t e;
        e.addr = a; e.wr = w; e.wdata = d; e.strb = s; e.prot = p;
        dn_q.push_back(e);
    endtask

    task automatic drop_port(input int p);
        if (p == 0) begin s0_psel = 1'b0; s0_penable = 1'b0; end
        else        begin s1_psel = 1'b0; s1_penable = 1'b0; end
    endtask

    // One requester-side APB transfer; lat = requester cycles from SETUP to pready.
    task automatic xfer(input int p, input logic [31:0] addr, input logic wr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        input logic [2:0] prot, output int lat);
        rsp_t r, got;
        bit   done;
        int   cyc;
        logic rdy, o_rdy, o_err;
        logic [31:0] rd, o_rd;
        logic err;
        r.rdata = br_base ^ addr;
        r.err   = br_err;
        if (p == 0) rsp_q0.push_back(r); else rsp_q1.push_back(r);
        done = 1'b0;
        cyc  = 0;
        @(posedge clk); #1;
        if (p == 0) begin
            s0_paddr = addr; s0_pwrite = wr; s0_pwdata = wdata; s0_pstrb = strb;
            s0_pprot = prot; s0_psel = 1'b1; s0_penable = 1'b0;
        end else begin
            s1_paddr = addr; s1_pwrite = wr; s1_pwdata = wdata; s1_pstrb = strb;
            s1_pprot = prot; s1_psel = 1'b1; s1_penable = 1'b0;
        end
        while (!done && cyc < 200) begin
            @(negedge clk); #2;
            cyc++;
            rdy   = (p == 0) ? s0_pready  : s1_pready;
            rd    = (p == 0) ? s0_prdata  : s1_prdata;
            err   = (p == 0) ? s0_pslverr : s1_pslverr;
            o_rdy = (p == 0) ? s1_pready  : s0_pready;
            o_rd  = (p == 0) ? s1_prdata  : s0_prdata;
            o_err = (p == 0) ? s1_pslverr : s0_pslverr;
            if (rdy === 1'b1) begin
                done = 1'b1;
                if (p == 0) got = rsp_q0.pop_front(); else got = rsp_q1.pop_front();
                n_cmp++;
                if (rd !== got.rdata) begin
                    n_bad++;
                    $display("FAIL s%0d_prdata: got %h, required %h", p, rd, got.rdata);
                end
                n_cmp++;
                if (err !== got.err) begin
                    n_bad++;
                    $display("FAIL s%0d_pslverr: got %b, required %b", p, err, got.err);
                end
                n_cmp++;
                if ({o_rdy, o_rd, o_err} !== 34'h0) begin
                    n_bad++;
                    $display("FAIL other_port_quiet: port %0d got rdy=%b rd=%h err=%b, required all 0",
                             1 - p, o_rdy, o_rd, o_err);
                end
            end
            @(posedge clk); #1;
            if (done) drop_port(p);
            else if (p == 0) s0_penable = 1'b1;
            else s1_penable = 1'b1;
        end
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL s%0d_timeout: got no pready in %0d cycles, required completion", p, cyc);
            drop_port(p);
        end
        lat = cyc;
    endtask

    function automatic logic model_winner();
`ifdef SPI_ARB_FIXED_PRIO_EN
        return 1'b0;
`else
        return ~tb_last;
`endif
    endfunction

    task automatic test_reset();
        resetn = 1'b0;
        s0_psel = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #2;
        n_cmp++;
        if ({m_psel, m_penable, m_paddr, m_pwdata, m_pstrb, m_pprot, m_pwrite} !== '0) begin
            n_bad++;
            $display("FAIL reset_master: got psel=%b en=%b a=%h d=%h, required all 0",
                     m_psel, m_penable, m_paddr, m_pwdata);
        end
        n_cmp++;
        if ({s0_pready, s0_prdata, s0_pslverr, s1_pready, s1_prdata, s1_pslverr} !== '0) begin
            n_bad++;
            $display("FAIL reset_slaves: got rdy0=%b rdy1=%b rd0=%h rd1=%h, required all 0",
                     s0_pready, s1_pready, s0_prdata, s1_prdata);
        end
        s0_psel = 1'b0;
        @(posedge clk); #1;
        resetn  = 1'b1;
        tb_last = 1'b1;
    endtask

    task automatic test_contest(input int pairs);
        int   l0, l1, lw, ll;
        logic w;
        for (int i = 0; i < pairs; i++) begin
            br_base = 32'h1234_0000 + 32'(i);
            w = model_winner();
            if (w == 1'b0) begin
                expect_dn(32'h3000_0000 + 32'(8*i), 1'b0, 32'h0, 4'h0, 3'b100);
                expect_dn(32'h1000_0004 + 32'(8*i), 1'b1, 32'h5A + 32'(i), 4'h1, 3'b000);
            end else begin
                expect_dn(32'h1000_0004 + 32'(8*i), 1'b1, 32'h5A + 32'(i), 4'h1, 3'b000);
                expect_dn(32'h3000_0000 + 32'(8*i), 1'b0, 32'h0, 4'h0, 3'b100);
            end
            tb_last = ~w;
            fork
                xfer(0, 32'h3000_0000 + 32'(8*i), 1'b0, 32'h0, 4'h0, 3'b100, l0);
                xfer(1, 32'h1000_0004 + 32'(8*i), 1'b1, 32'h5A + 32'(i), 4'h1, 3'b000, l1);
            join
            lw = w ? l1 : l0;
            ll = w ? l0 : l1;
            n_cmp++;
            if (lw !== 3) begin
                n_bad++;
                $display("FAIL contest%0d_winner_lat: got %0d, required 3", i, lw);
            end
            n_cmp++;
            if (ll < 6 || ll > 7) begin
                n_bad++;
                $display("FAIL contest%0d_loser_lat: got %0d, required 6..7", i, ll);
            end
        end
    endtask

    task automatic test_single_read();
        int lat;
        br_base = 32'hDEAD_BEEF ^ 32'h3000_0010;
        expect_dn(32'h3000_0010, 1'b0, 32'h0, 4'h0, 3'b010);
        tb_last = 1'b0;
        xfer(0, 32'h3000_0010, 1'b0, 32'h0, 4'h0, 3'b010, lat);
        n_cmp++;
        if (lat !== 3) begin
            n_bad++;
            $display("FAIL single_read_lat: got %0d, required 3", lat);
        end
    endtask

    task automatic test_stall();
        int lat;
        br_base = 32'h0BAD_F00D;
        br_wait = 20;
        expect_dn(32'h3000_0040, 1'b1, 32'hCAFE_0001, 4'hC, 3'b001);
        tb_last = 1'b0;
        xfer(0, 32'h3000_0040, 1'b1, 32'hCAFE_0001, 4'hC, 3'b001, lat);
        br_wait = 0;
        n_cmp++;
        if (lat !== 23) begin
            n_bad++;
            $display("FAIL stall_lat: got %0d, required 23", lat);
        end
        @(negedge clk); #2;
        n_cmp++;
        if ({s0_pready, m_psel} !== 2'b00) begin
            n_bad++;
            $display("FAIL stall_pready_once: got pready=%b psel=%b, required 0 0", s0_pready, m_psel);
        end
    endtask

    task automatic test_error();
        int lat;
        br_base = 32'h5555_AAAA;
        br_err  = 1'b1;
        expect_dn(32'h1000_0100, 1'b0, 32'h0, 4'h0, 3'b000);
        tb_last = 1'b1;
        xfer(1, 32'h1000_0100, 1'b0, 32'h0, 4'h0, 3'b000, lat);
        br_err = 1'b0;
        @(negedge clk); #2;
        n_cmp++;
        if ({s0_pslverr, s1_pslverr} !== 2'b00) begin
            n_bad++;
            $display("FAIL err_one_cycle: got s0=%b s1=%b, required 0 0", s0_pslverr, s1_pslverr);
        end
    endtask

    task automatic test_reset_mid_access();
        int   lat, cyc;
        br_wait = 50;
        expect_dn(32'h3000_0080, 1'b0, 32'h0, 4'h0, 3'b000);
        @(posedge clk); #1;
        s0_paddr = 32'h3000_0080; s0_pwrite = 1'b0; s0_pwdata = '0; s0_pstrb = '0;
        s0_pprot = '0; s0_psel = 1'b1; s0_penable = 1'b0;
        @(posedge clk); #1;
        s0_penable = 1'b1;
        cyc = 0;
        while (m_penable !== 1'b1 && cyc < 20) begin
            @(negedge clk); #2;
            cyc++;
        end
        n_cmp++;
        if (m_penable !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid_reach_access: got penable=%b, required 1", m_penable);
        end
        @(negedge clk); #1;
        resetn = 1'b0;
        #1;
        n_cmp++;
        if ({m_psel, m_penable, s0_pready, s1_pready, m_paddr} !== '0) begin
            n_bad++;
            $display("FAIL rst_mid_outputs: got psel=%b en=%b rdy0=%b rdy1=%b a=%h, required all 0",
                     m_psel, m_penable, s0_pready, s1_pready, m_paddr);
        end
        drop_port(0);
        br_wait = 0;
        @(posedge clk); #1;
        resetn  = 1'b1;
        tb_last = 1'b1;
        br_base = 32'h7777_0000;
        expect_dn(32'h1000_0200, 1'b1, 32'h0000_00A5, 4'hF, 3'b000);
        xfer(1, 32'h1000_0200, 1'b1, 32'h0000_00A5, 4'hF, 3'b000, lat);
        n_cmp++;
        if (lat !== 3) begin
            n_bad++;
            $display("FAIL rst_mid_recover_lat: got %0d, required 3", lat);
        end
    endtask

    initial begin
        resetn = 1'b0;
        s0_paddr = '0; s0_psel = 1'b0; s0_penable = 1'b0; s0_pprot = '0;
        s0_pwrite = 1'b0; s0_pwdata = '0; s0_pstrb = '0;
        s1_paddr = '0; s1_psel = 1'b0; s1_penable = 1'b0; s1_pprot = '0;
        s1_pwrite = 1'b0; s1_pwdata = '0; s1_pstrb = '0;

        test_reset();
        test_contest(3);
        test_single_read();
        test_stall();
        test_error();
        test_contest(2);
        test_reset_mid_access();

        repeat (3) @(posedge clk);
        n_cmp++;
        if (dn_q.size() != 0) begin
            n_bad++;
            $display("FAIL dn_leftover: got %0d pending transfers, required 0", dn_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
